// File: rtl/sag_iter.sv
// sag_iter: multi-cycle PEXT / PDEP / sheep-and-goats unit reusing one butterfly stage per cycle.
// Define SAG_POPCNT_EN to add the out_cnt port carrying popcount(in_mask) alongside each result.
module sag_iter #(
   parameter int W = 8,
   localparam int LOG2W = $clog2(W)
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_mode,
   input  logic [W-1:0] in_data,
   input  logic [W-1:0] in_mask,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
`ifdef SAG_POPCNT_EN
   ,
   output logic [LOG2W:0] out_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, DECODE, STAGE, DONE} state_t;
   state_t           r_state, w_nstate;
   logic [1:0]       r_mode;
   logic [W-1:0]     r_data, r_mask, r_x, r_part, r_out;
   logic [W-1:0]     r_ctl [LOG2W];
   logic [W-1:0]     w_ctl [LOG2W];
   logic [LOG2W-1:0] r_stg, w_sel;
   logic [LOG2W:0]   r_k, w_k;
   logic             r_pass;
   logic             w_pdep, w_sag, w_last;
   logic [W-1:0]     w_am, w_c, w_nx;

   assign w_pdep   = r_mode == 2'b01;
   assign w_sag    = r_mode == 2'b10;
   assign w_am     = r_pass ? ~r_mask : r_mask;
   assign w_last   = r_stg == LOG2W'(LOG2W - 1);
   assign w_sel    = w_pdep ? LOG2W'(LOG2W - 1) - r_stg : r_stg;
   assign out_data = r_out;

   // stage controls: each active bit travels right by its count of inactive bits below; bit i of that count acts at stage i
   always_comb begin
      int z;
      logic [LOG2W-1:0] p;
      z = 0;
      p = '0;
      for (int i = 0; i < LOG2W; i++) w_ctl[i] = '0;
      for (int j = 0; j < W; j++) begin
         if (w_am[j]) begin
            for (int i = 0; i < LOG2W; i++) begin
               p = LOG2W'(j - (z & ((1 << i) - 1)));
               if (z[i]) w_ctl[i][p] = 1'b1;
            end
         end else begin
            z = z + 1;
         end
      end
      w_k = (LOG2W + 1)'(W - z);
   end

   // one network stage of span 2**w_sel: compress right for PEXT/SAG, expand left for PDEP
   always_comb begin
      w_c = '0;
      for (int i = 0; i < LOG2W; i++) w_c = (w_sel == LOG2W'(i)) ? r_ctl[i] : w_c;
      w_nx = w_pdep ? (r_x & ~w_c) | ((r_x << (1 << w_sel)) & w_c)
                    : (r_x & ~w_c) | ((r_x & w_c) >> (1 << w_sel));
   end

   // state register
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) r_state <= IDLE;
      else r_state <= w_nstate;

   // next state and handshake outputs
   always_comb begin
      w_nstate  = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_nstate = DECODE;
         end
         DECODE: w_nstate = STAGE;
         STAGE: if (w_last) w_nstate = (w_sag && !r_pass) ? DECODE : DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_nstate = IDLE;
         end
         default: w_nstate = IDLE;
      endcase
   end

   // datapath: latch request, load stage controls, step the network, form the result
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mode <= '0;
         r_data <= '0;
         r_mask <= '0;
         r_x    <= '0;
         r_part <= '0;
         r_out  <= '0;
         r_stg  <= '0;
         r_k    <= '0;
         r_pass <= 1'b0;
         for (int i = 0; i < LOG2W; i++) r_ctl[i] <= '0;
      end else begin
         if (r_state == IDLE && in_valid) begin
            r_mode <= in_mode;
            r_data <= in_data;
            r_mask <= in_mask;
            r_pass <= 1'b0;
         end
         if (r_state == DECODE) begin
            for (int i = 0; i < LOG2W; i++) r_ctl[i] <= w_ctl[i];
            r_stg <= '0;
            r_x   <= w_pdep ? r_data : r_data & w_am;
            if (!r_pass) r_k <= w_k;
         end
         if (r_state == STAGE) begin
            r_x   <= w_nx;
            r_stg <= r_stg + LOG2W'(1);
            if (w_last) begin
               if (w_sag && !r_pass) begin
                  r_part <= w_nx;
                  r_pass <= 1'b1;
               end else begin
                  r_out <= w_pdep ? w_nx & r_mask : w_sag ? r_part | (w_nx << r_k) : w_nx;
               end
            end
         end
      end
   end

`ifdef SAG_POPCNT_EN
   logic [LOG2W:0] r_cnt;
   assign out_cnt = r_cnt;
   // mask popcount published on the same edge as the result
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) r_cnt <= '0;
      else if (r_state == STAGE && w_last && !(w_sag && !r_pass)) r_cnt <= r_k;
`endif
endmodule

// File: doc/sag_iter.md
Name: sag_iter

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational PEXT unit.
- Performs PEXT, PDEP or full sheep-and-goats (SAG) on a W-bit word.
- Reuses one butterfly/inverse-butterfly stage per cycle under FSM control, so area stays small as W grows.
- Sits behind a valid/ready request port and in front of a valid/ready result port in the bit-manipulation datapath.

Parameters:
- W, 8, data width; power of two, 8..64.
- LOG2W, $clog2(W), number of butterfly stages; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_mode  input  2  00 PEXT, 01 PDEP, 10 SAG, 11 reserved (executes as PEXT).
- in_data  input  W  data operand.
- in_mask  input  W  control mask.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_data  output  W  result.

Behaviour:
- Reset (async assert, resetn low): state=IDLE, in_ready=1, out_valid=0, out_data=0, all internal registers 0.
- Deassertion is synchronised by the integrator.
- Reset asserted mid-operation aborts the operation; no result is ever produced for it.
- Functions, where popcount(m)=k:
  - PEXT: out = mask-selected bits of data packed to LSBs in order; upper W-k bits 0.
  - PDEP: low k bits of data scattered to mask-set positions in order; other bits 0.
  - SAG: out = PEXT(data,mask) | (PEXT(data,~mask) << k).
- FSM states: IDLE, DECODE, STAGE, DONE.
  - IDLE: in_ready=1. On accept, latch mode/data/mask and go to DECODE. in_ready=0 in every other state.
  - DECODE (1 cycle): compute prefix popcounts of the active mask (mask, or ~mask on the SAG second pass) and register all LOG2W stage control words. Stage counter set to 0.
  - STAGE (LOG2W cycles): apply one butterfly stage per cycle.
    - PEXT/SAG: inverse butterfly, stage order 1,2,4..W/2; operand pre-masked with active mask.
    - PDEP: butterfly, order W/2..1; result post-masked with mask.
    - After the last stage, PEXT/PDEP go to DONE.
    - SAG first pass: store partial result, set pass=1, return to DECODE with ~mask.
    - SAG second pass: OR the shifted result with the partial result, go to DONE.
  - DONE: out_valid=1; out_data registered and held stable until out_ready. On out_ready, out_valid drops next cycle and state returns to IDLE.
- Latency, accept edge to first out_valid cycle:
  - PEXT/PDEP: LOG2W+1 cycles.
  - SAG: 2*LOG2W+2 cycles.
- Throughput: one operation in flight; next accept no earlier than the cycle after result consumption.
- Boundaries:
  - mask=0: PEXT/PDEP give 0; SAG gives data unchanged in order.
  - mask=all-ones: PEXT/PDEP give data; SAG gives data.
  - Shift by k=W in SAG yields 0 contribution (no wrap).
  - Popcounts are LOG2W+1 bits wide; stage control uses the low bits per stage (rotate-and-compare decode), never overflowing.
  - in_valid while busy is ignored (not queued); in_* may change freely when in_ready=0.
  - out_ready high while out_valid=0 has no effect.

Optional Feature:
- SAG_POPCNT_EN: adds port out_cnt output LOG2W+1 bits = popcount(in_mask) of the operation, valid and stable with out_data; reset value 0.
- Without the macro, the port and its register are absent. Function and latency are unchanged either way.

Test Plan (W=8, LOG2W=3 unless noted):
- PEXT data=0xB5 mask=0xF0, out_ready=1 -> out_data=0x0B; out_valid first high exactly 4 cycles after accept, one cycle wide.
- PDEP data=0x0B mask=0xF0 -> 0xB0; PDEP data=0xFF mask=0x55 -> 0x55.
- SAG data=0xB5 mask=0xF0 -> 0x5B after 8 cycles; SAG mask=0x00 and mask=0xFF with data=0xA7 -> 0xA7 both.
- Backpressure: out_ready low 3 cycles after out_valid -> out_data/out_valid stable, in_ready=0 throughout. Second request with in_valid held high is accepted the cycle after consumption.
- resetn pulsed low during STAGE of a SAG op -> out_valid never rises for that op; in_ready=1 immediately; subsequent PEXT data=0xFF mask=0x81 -> 0x03.
- W=32 random sweep (10k ops, all modes incl. 11) vs software model; latency 6 / 12 cycles. With SAG_POPCNT_EN, out_cnt matches popcount(mask).
